// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl
// ------------------
// SCAN (collective-directional) elevator car controller for an N-floor
// building. It latches car calls and directional hall calls, serves them
// sweep by sweep, and times inter-floor travel and door dwell with one
// shared timer.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high
//   car_call        in-car floor buttons, one bit per floor (level)
//   hall_up         hall up buttons (top-floor bit ignored)
//   hall_down       hall down buttons (ground-floor bit ignored)
//   door_open_req   in-car door-open button
//   door_close_req  in-car door-close button
//   alarm           emergency stop; freezes motion and timers while high
//   floor           current or last-passed floor index
//   dir_up/dir_down committed travel direction (both low = none)
//   moving          car is between floors
//   door_open       door is open
//   arrive          one-cycle pulse on each floor-index update
//   car_pend, up_pend, down_pend  latched call lamps
//   alarm_led       registered copy of alarm
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 5,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 500_000_000,
    parameter int DOOR_CYCLES   = 300_000_000,
    parameter int CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_call,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_down,
    input  logic                  door_open_req,
    input  logic                  door_close_req,
    input  logic                  alarm,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive,
    output logic [NUM_FLOORS-1:0] car_pend,
    output logic [NUM_FLOORS-1:0] up_pend,
    output logic [NUM_FLOORS-1:0] down_pend,
    output logic                  alarm_led
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    // There is no up call at the top floor and no down call at the ground.
    localparam logic [NUM_FLOORS-1:0] UP_VALID   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DOWN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0]      TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
    localparam logic [FLOOR_W-1:0]    FLOOR_ONE   = FLOOR_W'(1);

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        timer, timer_nx;
    logic [FLOOR_W-1:0]      floor_nx;
    logic                    dir_up_nx, dir_down_nx, arrive_nx;
    logic                    dir_none;

    logic [NUM_FLOORS-1:0]   at_mask, above_mask, below_mask, all_pend;
    logic                    pend_above, pend_below, any_pend;
    logic                    car_here, up_here, down_here;

    logic [NUM_FLOORS-1:0]   up_btn, down_btn;
    logic [NUM_FLOORS-1:0]   car_absorb, up_absorb, down_absorb;
    logic [NUM_FLOORS-1:0]   car_set, up_set, down_set;
    logic [NUM_FLOORS-1:0]   clr_car, clr_up, clr_down;
    logic                    door_restart;

    assign dir_none  = !dir_up && !dir_down;
    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_open = (state == DOOR);

    // Floor-relative masks; all scheduling decisions use the registered floor.
    always_comb begin
        at_mask    = '0;
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            at_mask[i]    = (i == int'(floor));
            above_mask[i] = (i >  int'(floor));
            below_mask[i] = (i <  int'(floor));
        end
    end

    assign all_pend   = car_pend | up_pend | down_pend;
    assign pend_above = |(all_pend & above_mask);
    assign pend_below = |(all_pend & below_mask);
    assign any_pend   = |all_pend;
    assign car_here   = |(car_pend & at_mask);
    assign up_here    = |(up_pend & at_mask);
    assign down_here  = |(down_pend & at_mask);

    // Button latching. With the door open, a press that the open door already
    // serves is absorbed and re-arms the dwell instead of lighting a lamp.
    always_comb begin
        up_btn      = hall_up & UP_VALID;
        down_btn    = hall_down & DOWN_VALID;
        car_absorb  = '0;
        up_absorb   = '0;
        down_absorb = '0;
        if (state == DOOR) begin
            car_absorb = car_call & at_mask;
            if (dir_up || dir_none)
                up_absorb = up_btn & at_mask;
            if (dir_down || dir_none)
                down_absorb = down_btn & at_mask;
        end
        car_set      = car_call & ~car_absorb;
        up_set       = up_btn & ~up_absorb;
        down_set     = down_btn & ~down_absorb;
        door_restart = |{car_absorb, up_absorb, down_absorb};
    end

    // Next-state / scheduling logic.
    always_comb begin
        state_nx    = state;
        floor_nx    = floor;
        dir_up_nx   = dir_up;
        dir_down_nx = dir_down;
        timer_nx    = timer;
        arrive_nx   = 1'b0;
        clr_car     = '0;
        clr_up      = '0;
        clr_down    = '0;

        if (alarm) begin
            // Everything freezes, including a pending arrive pulse.
            arrive_nx = arrive;
        end else begin
            unique case (state)
                IDLE: begin
                    timer_nx = '0;
                    if (car_here || (up_here && (dir_up || dir_none)) ||
                        (down_here && (dir_down || dir_none))) begin
                        state_nx = DOOR;
                        clr_car  = at_mask;
                        if (dir_up || dir_none)
                            clr_up = at_mask;
                        if (dir_down || dir_none)
                            clr_down = at_mask;
                    end else if (!any_pend) begin
                        dir_up_nx   = 1'b0;
                        dir_down_nx = 1'b0;
                        if (door_open_req)
                            state_nx = DOOR;
                    end else if (dir_up) begin
                        if (pend_above) begin
                            state_nx = MOVE_UP;
                        end else begin
                            // Reverse. If the only call left is an opposite
                            // hall call here, the flip alone lets the next
                            // decision open the door.
                            dir_up_nx   = 1'b0;
                            dir_down_nx = 1'b1;
                            if (pend_below)
                                state_nx = MOVE_DOWN;
                        end
                    end else if (dir_down) begin
                        if (pend_below) begin
                            state_nx = MOVE_DOWN;
                        end else begin
                            dir_up_nx   = 1'b1;
                            dir_down_nx = 1'b0;
                            if (pend_above)
                                state_nx = MOVE_UP;
                        end
                    end else if (pend_above) begin
                        dir_up_nx = 1'b1;
                        state_nx  = MOVE_UP;
                    end else if (pend_below) begin
                        dir_down_nx = 1'b1;
                        state_nx    = MOVE_DOWN;
                    end
                end

                MOVE_UP: begin
                    // The cycle after arrive is where the stop is decided;
                    // it also counts as the first travel cycle if we pass.
                    if (arrive && (car_here || up_here || !pend_above)) begin
                        state_nx = DOOR;
                        timer_nx = '0;
                        clr_car  = at_mask;
                        clr_up   = at_mask;
                        if (!pend_above) begin
                            dir_up_nx   = 1'b0;
                            dir_down_nx = 1'b1;
                            clr_down    = at_mask;
                        end
                    end else if (timer == TRAVEL_LAST) begin
                        floor_nx  = floor + FLOOR_ONE;
                        arrive_nx = 1'b1;
                        timer_nx  = '0;
                    end else begin
                        timer_nx = timer + CNT_ONE;
                    end
                end

                MOVE_DOWN: begin
                    if (arrive && (car_here || down_here || !pend_below)) begin
                        state_nx = DOOR;
                        timer_nx = '0;
                        clr_car  = at_mask;
                        clr_down = at_mask;
                        if (!pend_below) begin
                            dir_up_nx   = 1'b1;
                            dir_down_nx = 1'b0;
                            clr_up      = at_mask;
                        end
                    end else if (timer == TRAVEL_LAST) begin
                        floor_nx  = floor - FLOOR_ONE;
                        arrive_nx = 1'b1;
                        timer_nx  = '0;
                    end else begin
                        timer_nx = timer + CNT_ONE;
                    end
                end

                DOOR: begin
                    // Open request outranks close.
                    if (door_open_req || door_restart) begin
                        timer_nx = '0;
                    end else if (door_close_req || (timer == DOOR_LAST)) begin
                        state_nx = IDLE;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + CNT_ONE;
                    end
                end

                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            floor     <= '0;
            dir_up    <= 1'b0;
            dir_down  <= 1'b0;
            timer     <= '0;
            arrive    <= 1'b0;
            car_pend  <= '0;
            up_pend   <= '0;
            down_pend <= '0;
            alarm_led <= 1'b0;
        end else begin
            state     <= state_nx;
            floor     <= floor_nx;
            dir_up    <= dir_up_nx;
            dir_down  <= dir_down_nx;
            timer     <= timer_nx;
            arrive    <= arrive_nx;
            // A press in the same cycle as a clear wins, so it is not lost.
            car_pend  <= (car_pend & ~clr_car) | car_set;
            up_pend   <= (up_pend & ~clr_up) | up_set;
            down_pend <= (down_pend & ~clr_down) | down_set;
            alarm_led <= alarm;
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed testbench for elevator_scan_ctrl with short travel/door timing.
module tb_elevator_scan_ctrl;

    localparam int NF = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] car_call = '0;
    logic [NF-1:0] hall_up = '0;
    logic [NF-1:0] hall_down = '0;
    logic          door_open_req = 1'b0;
    logic          door_close_req = 1'b0;
    logic          alarm = 1'b0;
    logic [2:0]    floor;
    logic          dir_up, dir_down, moving, door_open, arrive, alarm_led;
    logic [NF-1:0] car_pend, up_pend, down_pend;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    elevator_scan_ctrl #(
        .NUM_FLOORS(NF), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .car_call(car_call), .hall_up(hall_up),
        .hall_down(hall_down), .door_open_req(door_open_req),
        .door_close_req(door_close_req), .alarm(alarm), .floor(floor),
        .dir_up(dir_up), .dir_down(dir_down), .moving(moving),
        .door_open(door_open), .arrive(arrive), .car_pend(car_pend),
        .up_pend(up_pend), .down_pend(down_pend), .alarm_led(alarm_led)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until arrive is seen; returns tick count, or -1 on timeout.
    task automatic wait_arrive(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!arrive && cnt < 40);
        if (!arrive) cnt = -1;
    endtask

    // Counts cycles the door stays open, starting in an open-door cycle.
    task automatic measure_door(output int cnt);
        cnt = 0;
        while (door_open && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        // ---------------- reset state
        tick(); tick();
        chk("rst_floor", floor, 0);
        chk("rst_dir", {dir_up, dir_down}, 0);
        chk("rst_moving", moving, 0);
        chk("rst_door", door_open, 0);
        chk("rst_arrive", arrive, 0);
        chk("rst_pend", {car_pend, up_pend, down_pend}, 0);
        chk("rst_alarm_led", alarm_led, 0);
        reset = 1'b0;

        // ---------------- single car call to floor 3
        car_call = 5'b01000;
        tick();
        chk("t1_latch", car_pend, 5'b01000);
        chk("t1_idle", moving, 0);
        car_call = '0;
        tick();
        chk("t1_moving", moving, 1);
        chk("t1_dir_up", dir_up, 1);
        wait_arrive(n);
        chk("t1_arr1_cyc", n, 4);
        chk("t1_floor1", floor, 1);
        wait_arrive(n);
        chk("t1_arr2_cyc", n, 4);
        chk("t1_floor2", floor, 2);
        wait_arrive(n);
        chk("t1_arr3_cyc", n, 4);
        chk("t1_floor3", floor, 3);
        tick();
        chk("t1_door", door_open, 1);
        chk("t1_stop", moving, 0);
        chk("t1_pend_clr", car_pend, 0);
        measure_door(n);
        chk("t1_dwell", n, 3);
        tick();
        chk("t1_dir_none", {dir_up, dir_down}, 0);
        chk("t1_idle_end", {moving, door_open}, 0);

        // ---------------- directional skip from floor 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hall_down = 5'b00100;
        car_call  = 5'b10000;
        tick();
        chk("t2_latch_dn", down_pend, 5'b00100);
        hall_down = '0;
        car_call  = '0;
        tick();
        chk("t2_moving", moving, 1);
        wait_arrive(n);
        chk("t2_floor1", floor, 1);
        wait_arrive(n);
        chk("t2_floor2", floor, 2);
        tick();
        chk("t2_skip2", {moving, door_open}, 2'b10);
        chk("t2_dn_kept", down_pend, 5'b00100);
        wait_arrive(n);
        chk("t2_arr3_cyc", n, 3);
        chk("t2_floor3", floor, 3);
        wait_arrive(n);
        chk("t2_floor4", floor, 4);
        tick();
        chk("t2_door4", door_open, 1);
        chk("t2_reverse", {dir_up, dir_down}, 2'b01);
        chk("t2_car_clr", car_pend, 0);
        measure_door(n);
        chk("t2_dwell4", n, 3);
        tick();
        chk("t2_move_dn", {moving, dir_down}, 2'b11);
        wait_arrive(n);
        chk("t2_arr3b_cyc", n, 4);
        chk("t2_floor3b", floor, 3);
        wait_arrive(n);
        chk("t2_floor2b", floor, 2);
        tick();
        chk("t2_door2", door_open, 1);
        chk("t2_dn_clr", down_pend, 0);
        measure_door(n);
        tick();
        chk("t2_dir_none", {dir_up, dir_down}, 0);

        // ---------------- call at current floor, door buttons
        car_call = 5'b00100;
        tick();
        chk("t3_latch_here", car_pend, 5'b00100);
        chk("t3_not_open", door_open, 0);
        car_call = '0;
        tick();
        chk("t3_door_here", {moving, door_open}, 2'b01);
        chk("t3_floor", floor, 2);
        chk("t3_here_clr", car_pend, 0);
        tick();
        door_open_req = 1'b1;
        tick();
        door_open_req = 1'b0;
        measure_door(n);
        chk("t3_dwell_ext", n + 2, 5);
        door_open_req = 1'b1;
        tick();
        chk("t3_reentry", door_open, 1);
        door_open_req  = 1'b0;
        door_close_req = 1'b1;
        tick();
        chk("t3_close", door_open, 0);
        door_close_req = 1'b0;

        // ---------------- ignored bits, then reset mid-move
        car_call  = 5'b10000;
        hall_up   = 5'b10010;
        hall_down = 5'b00001;
        tick();
        chk("t4_car", car_pend, 5'b10000);
        chk("t4_up_ign", up_pend, 5'b00010);
        chk("t4_dn_ign", down_pend, 0);
        car_call  = '0;
        hall_up   = '0;
        hall_down = '0;
        tick(); tick(); tick();
        chk("t4_mid_move", {moving, dir_up}, 2'b11);
        chk("t4_mid_floor", floor, 2);
        reset = 1'b1;
        #2;
        chk("t4_async_floor", floor, 0);
        chk("t4_async_pend", {car_pend, up_pend, down_pend}, 0);
        chk("t4_async_out", {moving, door_open, dir_up, dir_down}, 0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("t4_no_retain", {moving, door_open, floor}, 0);

        // ---------------- alarm freeze mid-travel
        car_call = 5'b00010;
        tick();
        car_call = '0;
        tick();
        chk("t5_moving", moving, 1);
        tick(); tick();
        alarm   = 1'b1;
        hall_up = 5'b01000;
        tick();
        hall_up = '0;
        chk("t5_led", alarm_led, 1);
        chk("t5_latch_in_alarm", up_pend, 5'b01000);
        for (int k = 0; k < 9; k++) tick();
        chk("t5_frozen", {moving, arrive, floor}, 5'b10000);
        alarm = 1'b0;
        wait_arrive(n);
        chk("t5_arr_cyc", n, 2);
        chk("t5_floor", floor, 1);
        tick();
        chk("t5_door", door_open, 1);
        chk("t5_led_off", alarm_led, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
